// File: rtl/counter_event_capture.sv
// Event capture for the two board counters: detects wrap, crossing and compare
// edges, tags each with a timestamp and queues it in a first-word-fall-through FIFO.
module counter_event_capture #(
    parameter int DEPTH = 16
) (
    input  logic                       sys_clk,
    input  logic                       reset_n,
    input  logic [7:0]                 count1,
    input  logic [7:0]                 count2,
    input  logic [7:0]                 cmp_value,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       pop,
    output logic [31:0]                evt_data,
    output logic                       evt_valid,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    output logic                       evt_pulse
);
    localparam int TS_WIDTH = 16;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LVL_W    = PTR_W + 1;

    function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [2:0] inc);
        logic [8:0] sum;
        sum = {1'b0, acc} + {6'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [2:0] count_hits(input logic [4:0] h);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 5; i++) n = n + {2'd0, h[i]};
        return n;
    endfunction

    logic [31:0]         mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    level;
    logic [TS_WIDTH-1:0] ts;
    logic [7:0]          count1_p1, count2_p1;
    logic                primed;

    logic                armed;
    logic [4:0]          hit;
    logic [3:0]          code;
    logic [7:0]          value;
    logic [31:0]         entry;
    logic                push_req, pop_ok, full, push_ok, push_lost;
    logic [2:0]          drops;

    // Detection stage: compare current counter inputs with the previous cycle
    always_comb begin
        armed  = primed && enable;
        hit[0] = armed && (count1_p1 == 8'hFF) && (count1 == 8'h00);
        hit[1] = armed && (count1_p1 != 8'h80) && (count1 == 8'h80);
        hit[2] = armed && (count2_p1 != cmp_value) && (count2 == cmp_value);
        hit[3] = armed && (count2_p1 == 8'hFF) && (count2 == 8'h00);
        hit[4] = armed && (count2_p1 == 8'h00) && (count2 == 8'hFF);
    end

    // Lowest code wins when several events land in one cycle
    always_comb begin
        code  = 4'd0;
        value = 8'h00;
        if (hit[0]) begin
            code  = 4'd1;
            value = count1;
        end else if (hit[1]) begin
            code  = 4'd2;
            value = count1;
        end else if (hit[2]) begin
            code  = 4'd3;
            value = count2;
        end else if (hit[3]) begin
            code  = 4'd4;
            value = count2;
        end else if (hit[4]) begin
            code  = 4'd5;
            value = count2;
        end
    end

    always_comb begin
        entry     = {code, 4'd0, value, ts};
        push_req  = |hit;
        pop_ok    = pop && (level != '0);
        full      = (level == LVL_W'(DEPTH));
        push_ok   = push_req && (!full || pop_ok);
        push_lost = push_req && full && !pop_ok;
        drops     = (push_req ? count_hits(hit) - 3'd1 : 3'd0) + {2'd0, push_lost};
    end

    // Queue stage: pointers, level, status and timestamp
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ts         <= '0;
            count1_p1  <= 8'h00;
            count2_p1  <= 8'h00;
            primed     <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= 8'h00;
            evt_pulse  <= 1'b0;
        end else begin
            count1_p1 <= count1;
            count2_p1 <= count2;
            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level      <= '0;
                ts         <= '0;
                primed     <= 1'b0;
                overflow   <= 1'b0;
                drop_count <= 8'h00;
                evt_pulse  <= 1'b0;
            end else begin
                ts        <= ts + 16'd1;
                primed    <= 1'b1;
                evt_pulse <= push_ok;
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push_ok && !pop_ok)      level <= level + LVL_W'(1);
                else if (!push_ok && pop_ok) level <= level - LVL_W'(1);
                if (push_lost)    overflow   <= 1'b1;
                if (drops != 3'd0) drop_count <= sat_add(drop_count, drops);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!clear && push_ok) mem[wr_ptr] <= entry;
    end

    assign evt_data   = (level != '0) ? mem[rd_ptr] : 32'h0;
    assign evt_valid  = (level != '0);
    assign fifo_level = level;
endmodule

// File: doc/counter_event_capture.md
Name: counter_event_capture

Overview:
- Sits directly downstream of the two 8-bit board counters (count1 on a divided tick; count2 driven by up/down/auto).
- Watches both counter values and detects wrap, crossing and compare events.
- Tags each event with a free-running timestamp and queues it in a first-word-fall-through FIFO.
- The host drains the queue through wire-out and trigger endpoints: evt_data to a wire-out, pop from a trigger-in bit, evt_pulse to a trigger-out bit.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..64
TS_WIDTH, 16, timestamp counter width; fixed by the evt_data word format, not overridable

Ports:
sys_clk  in  1  single clock; everything below is synchronous to it
reset_n  in  1  asynchronous, active-low reset
count1  in  8  counter 1 value
count2  in  8  counter 2 value
cmp_value  in  8  compare value for count2
enable  in  1  1 = event detection on
clear  in  1  synchronous flush, level-sensitive
pop  in  1  one-cycle pulse; removes the head entry
evt_data  out  32  head entry: [31:28] code, [27:24] 0, [23:16] counter value, [15:0] timestamp
evt_valid  out  1  FIFO not empty
fifo_level  out  log2(DEPTH)+1  number of stored entries
overflow  out  1  sticky; an event was lost because the FIFO was full
drop_count  out  8  saturating count of lost events (full or collision)
evt_pulse  out  1  one-cycle high on each accepted push

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; pointers, timestamp, prev registers and primed flag cleared.
- Timestamp: TS_WIDTH counter, +1 every cycle, wraps 0xFFFF->0x0000. It runs regardless of enable.
- Prev registers p1/p2 take count1/count2 every cycle.
- Primed flag: 0 after reset or clear, 1 after the first cycle. Detection is qualified by primed AND enable.
  - While primed=0, p1/p2 load and no event fires.
  - p1/p2 also update while enable=0, so re-enabling never produces a spurious event.
- Event codes (an edge compares the current input with prev):
  - 1: count1 wrap, p1=0xFF and count1=0x00
  - 2: count1 reaches 0x80, p1!=0x80 and count1=0x80
  - 3: count2 compare entry, p2!=cmp_value and count2=cmp_value
  - 4: count2 wrap up, p2=0xFF and count2=0x00
  - 5: count2 wrap down, p2=0x00 and count2=0xFF
- Captured value: count1 for codes 1-2, count2 for codes 3-5. The timestamp is the value in the detection cycle.
- Simultaneous events: at most one push per cycle. The lowest code wins; each other event detected that cycle adds 1 to drop_count. overflow is not set by a collision.
- Latency: the entry is written at the edge ending the detection cycle. evt_valid, fifo_level and evt_pulse update in the next cycle.
- evt_data: combinational read of mem[rd_ptr], first-word-fall-through. It reads 0 when empty.
- Pop:
  - pop while empty: ignored.
  - pop while valid: rd_ptr+1 and level-1 at the edge.
- Push while full without pop: the entry is dropped, overflow is set to 1, drop_count+1, and there is no evt_pulse.
- Push and pop in the same cycle:
  - Both take effect and the level is unchanged.
  - If full, the pop frees a slot, so the push is accepted and overflow is not set.
- drop_count saturates at 0xFF. Multiple drops in one cycle add together before saturating.
- clear (priority over push and pop):
  - empties the FIFO, zeroes overflow, drop_count and timestamp, and sets primed=0;
  - no events are captured during or one cycle after clear.
- Pointers are log2(DEPTH) bits and wrap naturally; the level counter distinguishes full from empty.

Test Plan:
- Reset then enable=1, count1 0xFE->0xFF->0x00 -> one entry, code 1, value 0x00, timestamp = detection cycle; evt_pulse one cycle; fifo_level=1.
- count2 0x00->0xFF with cmp_value=0xFF -> codes 3 and 5 in the same cycle -> code 3 stored, drop_count=1, overflow=0.
- Fill DEPTH=16 entries with count1 0x7F->0x80 toggles, no pop; next event -> fifo_level=16, overflow=1, drop_count=1, no evt_pulse. Then pop and push in the same cycle while full -> level stays 16, push accepted.
- Three entries queued, then 4 pops separated by idle cycles -> evt_data in push order, level 3->0, evt_valid=0 after the third pop, fourth pop ignored.
- enable=0 while count1 wraps, then enable=1 -> no entry. Assert clear with 5 entries, overflow=1 and timestamp=0x1234 -> level=0, overflow=0, drop_count=0, timestamp restarts at 0.
- Drive 300 overflow drops -> drop_count holds at 0xFF. reset_n low mid-operation, asynchronously -> all outputs 0 immediately. First cycle after reset with count2=0xFF -> no code-5 event.
